// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline-control definitions: forwarding selects, hazard FSM states and
// the multi-cycle latency default used by the stall/flush controller.
package hazard_stall_unit_pkg;

    // Operand forwarding selects (used by the bypass network next to this unit)
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_BUSY = 1'b1
    } hz_state_e;

    localparam int MC_LAT_DEFAULT = 4;
    localparam int MC_CNT_W       = 4;

    // A load in EX feeding a register the ID instruction reads; x0 is never a hazard.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       rs1_used,
        input logic [4:0] rs2,
        input logic       rs2_used
    );
        return mem_read && (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_mc_timer.sv
// Loadable down-counter with zero flag; times the remaining BUSY cycles of a
// multi-cycle EX operation.
module mc_timer
    import hazard_stall_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [MC_CNT_W-1:0] load_val_i,
    input  logic                dec_i,
    output logic [MC_CNT_W-1:0] cnt_o,
    output logic                zero_o
);

    logic [MC_CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - MC_CNT_W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use bubbles,
// multi-cycle EX holds, data-memory freezes and taken-branch flushes.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MC_LAT = MC_LAT_DEFAULT,  // legal range 2..16
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_multicycle,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_me,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_me,
    output logic             mc_done,
    output logic [CNT_W-1:0] stall_cnt
);

    // Cycles still stalled after the start cycle, excluding the final mc_done cycle
    localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LAT - 2);

    hz_state_e           state_q, state_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic [MC_CNT_W-1:0] tmr_cnt;
    logic                lu_hit;

    assign lu_hit = load_use_hit(ex_mem_read, ex_rd, id_rs1, id_rs1_used, id_rs2, id_rs2_used);

    mc_timer u_mc_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (MC_LOAD),
        .dec_i      (tmr_dec),
        .cnt_o      (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        stall_id_ex = 1'b0;
        stall_ex_me = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        flush_ex_me = 1'b0;
        mc_done     = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        state_d     = state_q;

        if (rst) begin
            state_d = HZ_RUN;
        end else if (dmem_busy) begin
            // Freeze: a taken branch stays parked in EX and is honoured afterwards
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
            stall_ex_me = 1'b1;
        end else if (state_q == HZ_RUN) begin
            if (ex_branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (ex_multicycle) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                stall_id_ex = 1'b1;
                flush_ex_me = 1'b1;
                tmr_load    = 1'b1;
                state_d     = HZ_BUSY;
            end else if (lu_hit) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end else if (!tmr_zero) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
            flush_ex_me = 1'b1;
            tmr_dec     = 1'b1;
        end else begin
            // ex_multicycle is ignored here so the finishing op does not restart
            mc_done = 1'b1;
            state_d = HZ_RUN;
        end
    end

    assign stall_cnt_d = stall_pc ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HZ_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus a random
// phase, with expected outputs queued at drive time and compared mid-cycle.
module tb_hazard_stall_unit;

    localparam int MC_LAT = 4;
    localparam int CNT_W  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_rs1_used, id_rs2_used;
    logic             ex_mem_read, ex_multicycle, ex_branch_taken, dmem_busy;
    logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_me;
    logic             flush_if_id, flush_id_ex, flush_ex_me, mc_done;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_multicycle   (ex_multicycle),
        .ex_branch_taken (ex_branch_taken),
        .dmem_busy       (dmem_busy),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .stall_id_ex     (stall_id_ex),
        .stall_ex_me     (stall_ex_me),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .flush_ex_me     (flush_ex_me),
        .mc_done         (mc_done),
        .stall_cnt       (stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: control bits {stall_pc,if_id,id_ex,ex_me, flush_if_id,id_ex,ex_me, mc_done}
    logic [7:0]  q_ctl[$];
    logic [31:0] q_cnt[$];
    string       q_tag[$];

    always @(negedge clk) begin
        if (q_ctl.size() > 0) begin
            automatic logic [7:0]  e_ctl = q_ctl.pop_front();
            automatic logic [31:0] e_cnt = q_cnt.pop_front();
            automatic string       t     = q_tag.pop_front();
            check({t, ".ctl"}, 32'({stall_pc, stall_if_id, stall_id_ex, stall_ex_me,
                                   flush_if_id, flush_id_ex, flush_ex_me, mc_done}), 32'(e_ctl));
            check({t, ".cnt"}, stall_cnt, e_cnt);
        end
    end

    // Reference model: busy_left counts BUSY cycles still to come (0 = running)
    int          busy_left = 0;
    logic [31:0] m_cnt     = 0;

    // Drive one cycle of inputs (just after posedge), queue expectation, advance model.
    task automatic step(input string tag, input logic r, input logic dm, input logic br,
                        input logic mc, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2);
        logic [7:0] e;
        logic       hit;
        rst = r; dmem_busy = dm; ex_branch_taken = br; ex_multicycle = mc;
        ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs1_used = u1;
        id_rs2 = rs2; id_rs2_used = u2;

        hit = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e = 8'b0;
        if (r)                   e = 8'b0;
        else if (dm)             e = 8'b1111_0000;
        else if (busy_left == 1) e = 8'b0000_0001;
        else if (busy_left > 1)  e = 8'b1110_0010;
        else if (br)             e = 8'b0000_1100;
        else if (mc)             e = 8'b1110_0010;
        else if (hit)            e = 8'b1100_0100;

        q_ctl.push_back(e);
        q_cnt.push_back(m_cnt);
        q_tag.push_back(tag);

        if (r) begin
            busy_left = 0;
            m_cnt     = 0;
        end else begin
            if (e[7]) m_cnt = m_cnt + 1;
            if (!dm) begin
                if (busy_left > 0)  busy_left--;
                else if (!br && mc) busy_left = MC_LAT - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    endtask

    initial begin
        rst = 1'b1; dmem_busy = 0; ex_branch_taken = 0; ex_multicycle = 0;
        ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        @(posedge clk);
        #1;

        step("reset", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);

        // Load-use on rs2, then a quiet cycle showing stall_cnt=1
        step("lu_rs2", 0, 0, 0, 0, 1, 5'd5, 5'd1, 1, 5'd5, 1);
        idle("lu_after");
        // x0 and unused-operand cases never stall
        step("lu_x0", 0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
        step("lu_unused", 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd3, 1);

        // Multi-cycle op with ex_multicycle held throughout
        step("mc_rst", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        for (int i = 0; i < MC_LAT; i++) step($sformatf("mc_%0d", i), 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        idle("mc_cnt3");

        // Freeze for 2 cycles while BUSY with cnt=1
        step("fz_start", 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        step("fz_cnt2", 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        step("fz_f0", 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        step("fz_f1", 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        step("fz_cnt1", 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        step("fz_done", 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        idle("fz_after");

        // Branch beats load-use; during a freeze the flush waits
        step("br_lu", 0, 0, 1, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0);
        step("br_fz0", 0, 1, 1, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0);
        step("br_fz1", 0, 1, 1, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0);
        step("br_rel", 0, 0, 1, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0);
        step("br_mc", 0, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);

        // Reset in BUSY with cnt=2: no mc_done afterwards
        step("rb_start", 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        step("rb_rst", 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        idle("rb_idle0");
        idle("rb_idle1");
        idle("rb_idle2");

        // Random mix with small register indices to provoke matches
        for (int i = 0; i < 200; i++) begin
            step($sformatf("rnd_%0d", i),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        check("queue_drained", 32'(q_ctl.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage RV32 pipeline, and the counterpart of operand forwarding: it handles the hazards that bypassing cannot resolve.
- It inserts load-use bubbles, holds the pipeline while a multi-cycle EX op (mul/div) completes, freezes everything while data memory is busy, and flushes wrong-path instructions on a taken branch or jump.
- Outputs drive the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
- MC_LAT, 4, total EX-residency cycles of a multi-cycle op (legal range 2..16).
- CNT_W, 32, width of the stall-cycle statistics counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- id_rs1  input  5  rs1 index of the instruction in ID
- id_rs2  input  5  rs2 index of the instruction in ID
- id_rs1_used  input  1  ID instruction reads rs1
- id_rs2_used  input  1  ID instruction reads rs2
- ex_rd  input  5  rd of the instruction in EX
- ex_mem_read  input  1  EX instruction is a load
- ex_multicycle  input  1  EX instruction is a multi-cycle op
- ex_branch_taken  input  1  EX resolved a taken branch or jump
- dmem_busy  input  1  data memory not ready; MEM must hold
- stall_pc  output  1  hold PC
- stall_if_id  output  1  hold IF/ID
- stall_id_ex  output  1  hold ID/EX
- stall_ex_me  output  1  hold EX/MEM
- flush_if_id  output  1  bubble into IF/ID
- flush_id_ex  output  1  bubble into ID/EX
- flush_ex_me  output  1  bubble into EX/MEM
- mc_done  output  1  last EX cycle of a multi-cycle op; result valid
- stall_cnt  output  CNT_W  cycles in which stall_pc=1 (wraps at 2^CNT_W)

Behaviour:
- State machine: RUN and BUSY. 4-bit down-counter cnt.
- Reset: state=RUN, cnt=0, stall_cnt=0. All other outputs are combinational and evaluate to 0 under reset input values.
- Priority, highest first: rst, freeze, flush, multi-cycle, load-use.
- Freeze (dmem_busy=1, any state):
  - All stall_* = 1; all flush_* = 0; mc_done = 0.
  - state and cnt hold.
  - A taken branch stays in EX and is honoured after the freeze ends.
- Flush (RUN, ex_branch_taken=1): flush_if_id = flush_id_ex = 1. Overrides any load-use match in the same cycle.
- Multi-cycle start (RUN, ex_multicycle=1, no flush):
  - stall_pc = stall_if_id = stall_id_ex = 1; flush_ex_me = 1.
  - Next state BUSY, cnt = MC_LAT-2.
- BUSY, cnt != 0: same four outputs as multi-cycle start; cnt decrements.
- BUSY, cnt == 0: mc_done = 1; no stall or flush; next state RUN.
  - ex_multicycle is ignored in BUSY, so the same op does not restart.
- Net effect: an op occupies EX for exactly MC_LAT cycles, with MC_LAT-1 stalled cycles. MC_LAT=2 gives a single BUSY cycle with cnt=0.
- Load-use (RUN, none of the above):
  - Hit when ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - Response: stall_pc = stall_if_id = 1, flush_id_ex = 1, for exactly one cycle. Afterwards the load is in MEM and is served by MEM/WB forwarding.
- x0 never causes a stall.
- stall_cnt increments every cycle stall_pc=1, including freeze cycles.
- Reset asserted mid-BUSY: the next cycle is RUN with cnt=0, and no mc_done is emitted.

Decomposition:
- Shared define file: state encodings (HZ_RUN, HZ_BUSY) and the MC_LAT default, placed alongside the existing forwarding-select constants.
- One sub-module, mc_timer: loadable down-counter with a zero flag. It is instantiated once for cnt.

Test Plan:
- Load x5 in EX, ID reads rs2=x5 with rs2_used=1 -> one cycle of stall_pc=1, flush_id_ex=1; next cycle all 0; stall_cnt=1.
- Load with ex_rd=0, id_rs1=0 -> no stall. Repeat with id_rs1_used=0 and matching index -> no stall.
- ex_multicycle=1 with MC_LAT=4 -> stall_pc high for 3 cycles; mc_done high in the 4th cycle; state back to RUN; stall_cnt=3.
- dmem_busy held 2 cycles during BUSY with cnt=1 -> cnt holds, all stalls high; mc_done arrives 2 cycles later than without the freeze.
- ex_branch_taken together with a load-use match -> flush_if_id=flush_id_ex=1, stall_pc=0. Repeat with dmem_busy=1 -> flushes 0 until dmem_busy falls.
- rst asserted in BUSY with cnt=2 -> next cycle RUN, mc_done never pulses, stall_cnt=0.
